prim_cmd_queue: RTL
===================

Name: prim_cmd_queue

Overview:
Command FIFO and sequencer sitting directly upstream of the primitive renderer. It buffers 16-bit primitive commands written by the host register interface and replays them to the renderer's cmd_i/cmd_valid_i port. It withholds every command while a primitive is being drawn, so that coordinate, colour and destination registers never change under an active draw and no EXECUTE is lost. The host can therefore queue several complete primitives back to back.

Parameters:
DEPTH, 16, FIFO entries; must be a power of 2, minimum 4.
EXEC_OPCODE, 4'hF, value of cmd[15:12] treated as execute; instantiate with xv::PR_EXECUTE.
SETTLE_CYCLES, 3, clocks to wait after issuing an execute before sampling busy_i; covers the renderer start-to-busy latency; minimum 1.

Ports:
clk  input  1  system clock
reset_n_i  input  1  asynchronous active-low reset
host_cmd_i  input  16  command word from host; [15:12] opcode, [11:0] payload
host_cmd_valid_i  input  1  push strobe, one command per high cycle
flush_i  input  1  synchronous FIFO clear
busy_i  input  1  renderer busy_o
cmd_o  output  16  command to renderer cmd_i
cmd_valid_o  output  1  one-cycle strobe to renderer cmd_valid_i
full_o  output  1  FIFO holds DEPTH entries
empty_o  output  1  FIFO holds 0 entries
level_o  output  $clog2(DEPTH)+1  current entry count
overflow_o  output  1  sticky: a push was dropped
idle_o  output  1  empty_o && state==IDLE && !busy_i

Behaviour:
- Reset: the clock and reset are decided: one clock, clk; reset is asynchronous and active-low, reset_n_i. Asserting reset clears the FIFO pointers, level_o=0, the state to IDLE and the settle counter. Output values under reset: cmd_o=0, cmd_valid_o=0, overflow_o=0, full_o=0, empty_o=1. Reset mid-draw drops all queued and in-flight commands. Release is handled by the standard reset synchroniser outside this block.
- FIFO: circular buffer with rd/wr pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. level_o is a separate counter.
- Push acceptance: a push is accepted when level<DEPTH, or when a pop happens in the same cycle (push+pop at full is accepted and level stays DEPTH).
- Push rejection: a push to a full FIFO with no pop is dropped and sets overflow_o. overflow_o clears only on flush_i or reset.
- Flush: flush_i empties the FIFO (level=0) and clears overflow_o. It has priority over a push in the same cycle. It does not change the state machine, because the renderer may still be drawing.
- Pop condition: state==IDLE && !busy_i && level!=0 && !flush_i. A pop registers the head word into cmd_o and drives cmd_valid_o=1 for exactly the next cycle.
- cmd_o holds its last value when cmd_valid_o=0.
- Throughput: one non-execute command per clock.
- Latency: a push into an empty idle queue at clock edge k gives a pop at edge k+1 and cmd_valid_o high in the cycle after edge k+1 (2 clocks).
- State machine:
  - IDLE: on a pop whose opcode==EXEC_OPCODE, go to SETTLE and load the counter with SETTLE_CYCLES-1. A pop of any other opcode stays in IDLE.
  - SETTLE: decrement the counter each clock. No pops. When the counter reaches 0, go to WAIT_BUSY.
  - WAIT_BUSY: no pops. When busy_i==0, go to IDLE. The next pop can occur on the edge after the return to IDLE.
- Unknown or unsupported execute sub-codes are forwarded unchanged; the renderer ignores them. If busy_i never rises, WAIT_BUSY exits immediately, so there is no deadlock.
- busy_i high in IDLE (from a foreign start) also blocks pops.
- A push at level 0 does not bypass the FIFO; the output is always registered from the FIFO head.

Test Plan:
- Reset/idle: hold reset_n_i=0, then release → cmd_valid_o=0, empty_o=1, level_o=0, idle_o=1.
- Stream: push 16'h0005, 16'h1003, 16'h2010, 16'h3020 on 4 consecutive clocks with busy_i=0 → cmd_valid_o high on 4 consecutive cycles starting 2 clocks after the first push, cmd_o in the same order, level_o returns to 0.
- Execute gating: push 16'hF000 then 16'h0007; model busy_i rising 2 clocks after the execute strobe and lasting 10 clocks → 16'h0007 is not presented until the cycle after busy_i falls plus one clock. Exactly one strobe per word.
- Full/overflow: with busy_i=1, push 17 words → full_o=1 after 16, overflow_o=1, level_o=16. Release busy → only the first 16 words emerge in order, with correct pointer wrap.
- Push+pop at full: with level_o=16 and draining, a push in the same cycle as a pop is accepted, level_o stays 16 and overflow_o stays 0.
- Flush and async reset mid-draw: flush_i during WAIT_BUSY → level_o=0 and overflow_o=0, state still waits for busy_i=0. Asserting reset_n_i mid-SETTLE immediately forces cmd_valid_o=0 and state IDLE, without waiting for a clock edge.

Source files
------------

// File: rtl/prim_cmd_queue.sv
// rtl/prim_cmd_queue.sv - command FIFO and execute sequencer ahead of the primitive renderer
//
// Buffers 16-bit host commands and replays them one per clock to the
// renderer. After an execute word is issued, further words are held back until
// the renderer has had time to raise busy and has then dropped it again. This
// keeps the renderer's registers stable during a draw.
//
// Ports:
//   clk, reset_n_i        clock, asynchronous active-low reset
//   host_cmd_i/_valid_i   host push port ([15:12] opcode, [11:0] payload)
//   flush_i               synchronous FIFO clear (also clears overflow_o)
//   busy_i                renderer busy
//   cmd_o/cmd_valid_o     registered command and one-cycle strobe to the renderer
//   full_o/empty_o        FIFO holds DEPTH / 0 entries
//   level_o               current entry count
//   overflow_o            sticky: a push was dropped
//   idle_o                nothing queued, sequencer idle, renderer not busy

module prim_cmd_queue #(
  parameter int unsigned DEPTH         = 16,
  parameter logic [3:0]  EXEC_OPCODE   = 4'hF,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     reset_n_i,
  input  logic [15:0]              host_cmd_i,
  input  logic                     host_cmd_valid_i,
  input  logic                     flush_i,
  input  logic                     busy_i,
  output logic [15:0]              cmd_o,
  output logic                     cmd_valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic                     idle_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WAIT_BUSY
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     cmd_q, cmd_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [15:0]     mem_q [DEPTH];

  logic [15:0]     head;
  logic            pop;
  logic            push_ok;

  assign head = mem_q[rd_ptr_q];

  // Storage is not reset: entries are only ever read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= host_cmd_i;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  // Next-state logic: FIFO bookkeeping and sequencer.
  always_comb begin
    pop     = (state_q == ST_IDLE) && !busy_i && (level_q != '0) && !flush_i;
    // A pop frees a slot in the same cycle, so a push at full still fits.
    push_ok = host_cmd_valid_i && !flush_i && ((level_q != LEVEL_FULL) || pop);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    cmd_valid_d = pop;
    cmd_d       = pop ? head : cmd_q;

    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop) begin
        level_d = level_q + 1'b1;
      end else if (!push_ok && pop) begin
        level_d = level_q - 1'b1;
      end
      if (host_cmd_valid_i && !push_ok) begin
        overflow_d = 1'b1;
      end
    end

    // Flush leaves the sequencer alone: the renderer may still be drawing.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pop && (head[15:12] == EXEC_OPCODE)) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        // Give the renderer time to raise busy before we look at it.
        if (cnt_q == '0) begin
          state_d = ST_WAIT_BUSY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT_BUSY: begin
        // If busy never rose, this exits at once and nothing deadlocks.
        if (!busy_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    cmd_o       = cmd_q;
    cmd_valid_o = cmd_valid_q;
    level_o     = level_q;
    overflow_o  = overflow_q;
    full_o      = (level_q == LEVEL_FULL);
    empty_o     = (level_q == '0);
    idle_o      = (level_q == '0) && (state_q == ST_IDLE) && !busy_i;
  end

endmodule
